// File: rtl/reg_dump_seq_pkg.sv
// Shared definitions for the debug register dump sequencer: FSM encoding,
// frame header default and the frame-length formula.
package reg_dump_seq_pkg;

   typedef enum logic [3:0] {
      IDLE, HDR, SEL, CAP, IDX, B3, B2, B1, B0, CSUM
   } state_t;

   localparam logic [7:0] HEADER_DEFAULT   = 8'hA5;
   localparam int         NUM_REGS_DEFAULT = 16;

   // Header + (index byte + 4 value bytes) per register + checksum.
   function automatic int frame_len(input int num_regs);
      return 2 + 5 * num_regs;
   endfunction

   localparam int FRAME_LEN_DEFAULT = frame_len(NUM_REGS_DEFAULT);

endpackage

// File: rtl/reg_dump_seq_if.sv
// Byte stream with valid/ready handshake; the producer owns data/valid.
interface reg_dump_seq_if;

   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/reg_dump_seq_stream_byte_out.sv
// Registered byte output stage: a load strobe fills the holding register,
// which is then held stable until the consumer accepts it.
module stream_byte_out (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_load,
   input  logic [7:0]    i_data,
   output logic          o_xfer,
   reg_dump_seq_if.master m
);

   logic [7:0] r_data;
   logic       r_valid;

   assign o_xfer      = r_valid & m.out_ready;
   assign m.out_data  = r_data;
   assign m.out_valid = r_valid;

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_valid <= 1'b1;
      end else if (o_xfer) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/reg_dump_seq.sv
// Steps the processor debug register select through R0..R(NUM_REGS-1) and
// streams a framed, checksummed byte dump of the sampled values.
module reg_dump_seq
   import reg_dump_seq_pkg::*;
#(
   parameter int         NUM_REGS = NUM_REGS_DEFAULT,
   parameter logic [7:0] HEADER   = HEADER_DEFAULT
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   output logic [3:0]     DBtheReg,
   input  logic [31:0]    DBtheRegVal,
   reg_dump_seq_if.master stream,
   output logic           busy,
   output logic           done
);

   localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_index, w_index_nxt;
   logic [7:0]  r_csum,  w_csum_nxt;
   logic [31:0] r_cap;
   logic [3:0]  r_db_reg;
   logic        r_done,  w_done_nxt;

   logic        w_cap_en;
   logic        w_load;
   logic [7:0]  w_load_data;
   logic        w_xfer;
   logic [7:0]  w_csum_sum;

   stream_byte_out u_out (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_load),
      .i_data (w_load_data),
      .o_xfer (w_xfer),
      .m      (stream)
   );

   // Running sum including the byte currently being accepted.
   assign w_csum_sum = r_csum + stream.out_data;

   assign DBtheReg = r_db_reg;
   assign busy     = (r_state != IDLE);
   assign done     = r_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_index  <= '0;
         r_csum   <= '0;
         r_cap    <= '0;
         r_db_reg <= '0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_index <= w_index_nxt;
         r_csum  <= w_csum_nxt;
         r_done  <= w_done_nxt;
         if (w_cap_en) r_cap <= DBtheRegVal;
         // Select is driven on SEL entry so the value settles a full cycle.
         if (w_state_nxt == SEL) r_db_reg <= w_index_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case statement can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_index_nxt = r_index;
      w_csum_nxt  = r_csum;
      w_done_nxt  = 1'b0;
      w_cap_en    = 1'b0;
      w_load      = 1'b0;
      w_load_data = '0;
      case (r_state)
         IDLE: if (start) begin
            w_state_nxt = HDR;
            w_index_nxt = '0;
            w_csum_nxt  = '0;
            w_load      = 1'b1;
            w_load_data = HEADER;
         end
         HDR:  if (w_xfer) w_state_nxt = SEL;
         SEL:  w_state_nxt = CAP;
         CAP: begin
            w_cap_en    = 1'b1;
            w_load      = 1'b1;
            w_load_data = {4'h0, r_index};
            w_state_nxt = IDX;
         end
         IDX: if (w_xfer) begin
            w_csum_nxt  = w_csum_sum;
            w_load      = 1'b1;
            w_load_data = r_cap[31:24];
            w_state_nxt = B3;
         end
         B3: if (w_xfer) begin
            w_csum_nxt  = w_csum_sum;
            w_load      = 1'b1;
            w_load_data = r_cap[23:16];
            w_state_nxt = B2;
         end
         B2: if (w_xfer) begin
            w_csum_nxt  = w_csum_sum;
            w_load      = 1'b1;
            w_load_data = r_cap[15:8];
            w_state_nxt = B1;
         end
         B1: if (w_xfer) begin
            w_csum_nxt  = w_csum_sum;
            w_load      = 1'b1;
            w_load_data = r_cap[7:0];
            w_state_nxt = B0;
         end
         B0: if (w_xfer) begin
            w_csum_nxt = w_csum_sum;
            if (r_index == LAST_IDX) begin
               w_load      = 1'b1;
               w_load_data = w_csum_sum;
               w_state_nxt = CSUM;
            end else begin
               w_index_nxt = r_index + 4'd1;
               w_state_nxt = SEL;
            end
         end
         CSUM: if (w_xfer) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/reg_dump_seq.md
Name: reg_dump_seq

Overview:
- Debug read-out stage directly downstream of the single-cycle processor's debug register port.
- On a start request it steps the debug register select through R0..R(NUM_REGS-1) and samples each register value.
- It serialises the samples into a framed byte stream with a valid/ready handshake, for a UART or bench monitor.
- The processor keeps running during a dump; each register is sampled at its own capture cycle, with no atomic snapshot across registers.

Parameters:
- NUM_REGS, 16: number of registers dumped, starting at R0; legal range 1..16.
- HEADER, 8'hA5: frame start byte.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  dump request; sampled only in IDLE.
- DBtheReg  output  4  debug register select, driven to the processor.
- DBtheRegVal  input  32  debug register value from the processor; combinational function of DBtheReg.
- out_data  output  8  stream byte.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts the byte.
- busy  output  1  high from start acceptance until the checksum byte is accepted.
- done  output  1  one-cycle pulse after the checksum byte is accepted.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=IDLE, DBtheReg=0, out_data=0, out_valid=0, busy=0, done=0;
  - index counter=0, checksum=0, capture register=0.
- Reset mid-frame aborts the frame immediately. No partial checksum or done is produced; a new start is required.
- Handshake:
  - A byte transfers on a clk edge where out_valid and out_ready are both 1.
  - While out_valid=1 and out_ready=0, out_data holds stable and out_valid stays high.
  - out_valid never depends combinationally on out_ready.
- Frame format, in order:
  - HEADER;
  - then for each register i=0..NUM_REGS-1: index byte {4'h0,i}, then value bytes [31:24], [23:16], [15:8], [7:0];
  - then the checksum byte.
  - Total length = 2+5*NUM_REGS bytes (82 for the default).
- Checksum: 8-bit sum modulo 256 of every byte after HEADER, checksum byte excluded. It is cleared when start is accepted.
- State machine:
  - IDLE: busy=0. start=1 -> HDR, busy=1, index=0.
  - HDR: out_valid=1, out_data=HEADER; on transfer -> SEL.
  - SEL: DBtheReg=index, out_valid=0; next cycle -> CAP. This gives one full cycle of settling.
  - CAP: latch DBtheRegVal into the capture register -> IDX.
  - IDX, B3, B2, B1, B0: present the index byte, then the captured bytes MSB first. Each state advances on transfer and adds its byte to the checksum.
  - After the B0 transfer: if index==NUM_REGS-1 -> CSUM; otherwise index+1 and -> SEL.
  - CSUM: present the checksum; on transfer -> IDLE, busy=0, done=1 for exactly one cycle.
- DBtheReg holds its value outside SEL and CAP; it is not required to return to 0.
- start while busy=1 is ignored: not queued, no effect on the frame.
- start held high continuously produces back-to-back frames, with one IDLE cycle between them.
- Minimum frame time with out_ready held at 1: 1 + 7*NUM_REGS + 1 cycles after start acceptance.
- The index counter never wraps: the NUM_REGS-1 compare terminates the frame, including when NUM_REGS=16.

Decomposition:
- Shared debug package holds:
  - state encoding constants (IDLE, HDR, SEL, CAP, IDX, B3, B2, B1, B0, CSUM);
  - the HEADER default;
  - the frame-length formula constant.
- One sub-module, stream_byte_out: the output holding register plus the valid/ready logic, with a load strobe and transfer indication. It is reused later by the UART transmitter glue.

Test Plan:
- NUM_REGS=2, register model R0=0x00000000, R1=0x12345678, out_ready=1, start pulse -> bytes A5 00 00 00 00 00 01 12 34 56 78 15; done pulses once; busy is high for 16 cycles.
- Same setup, out_ready toggling 1010... -> identical byte sequence; out_data is stable whenever out_valid=1 and out_ready=0.
- Default NUM_REGS=16 connected to the running processor, R15=PC+8 -> 82 bytes; index bytes run 00..0F; the checksum matches a bench-computed sum of the received bytes.
- start asserted again during the IDX state of R1 -> frame unchanged, exactly one done pulse.
- reset asserted asynchronously between clk edges during B2 -> out_valid=0, busy=0, DBtheReg=0 immediately; a later start yields a complete, correct frame starting with A5.
- start held high, out_ready=1 -> two consecutive frames separated by exactly one IDLE cycle; done pulses once per frame.
